mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch port and its data port.
- Sits between the core boundary and the memory/bus.
- Serialises requests through a small FSM, latches the address, write data and mask at grant, and returns read data with a one-cycle valid pulse.
- Drives a stall signal that feeds the IFU halt input while any core access is outstanding.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch
// port (i_*) and the data port (d_*), one transaction at a time.
// Ports: clk, rst (sync, active-low); i_req/i_addr -> i_rdata/i_rvalid;
// d_req/d_addr/d_wmask/d_wdata -> d_rdata/d_rvalid; mem_req/mem_addr/
// mem_wmask/mem_wdata -> memory, mem_ack/mem_rdata <- memory; o_stall.
// Build option: define ARB_RR_EN for round-robin conflict resolution,
// otherwise data always beats fetch.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_rvalid,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_wmask,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_rvalid,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_wmask,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            o_stall
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            pick_d, pick_i;

`ifdef ARB_RR_EN
  // 1 = fetch was served last, so data wins the next conflict.
  logic last_q, last_d;

  assign pick_d = d_req & ~(i_req & ~last_q);
`else
  assign pick_d = d_req;
`endif
  assign pick_i = i_req & ~pick_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_d: begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            wmask_d = d_wmask;
            wdata_d = d_wdata;
          end
          pick_i: begin
            state_d = BUSY_I;
            addr_d  = i_addr;
            wmask_d = '0;
            wdata_d = '0;
          end
          default: ;
        endcase
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d   = RESP_I;
          i_rdata_d = mem_rdata;
`ifdef ARB_RR_EN
          last_d    = 1'b1;
`endif
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = RESP_D;
          d_rdata_d = mem_rdata;
`ifdef ARB_RR_EN
          last_d    = 1'b0;
`endif
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign mem_req   = (state_q == BUSY_I) |
                     (state_q == BUSY_D);
  assign mem_addr  = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign i_rvalid  = (state_q == RESP_I);
  assign d_rvalid  = (state_q == RESP_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign o_stall   = (i_req & ~i_rvalid) |
                     (d_req & ~d_rvalid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Memory model acks after a programmable number of busy cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rvalid, d_rvalid;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        o_stall;

  logic        ack_force;
  int          delay;
  int          wcnt;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_addr(d_addr),
    .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_stall(o_stall)
  );

  assign mem_ack = ack_force |
                   (mem_req && (wcnt == delay));

  always @(posedge clk) begin
    if (!mem_req) wcnt <= 0;
    else if (!mem_ack) wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    int          pulses;
    wcnt      = 0;
    rst       = 1'b0;
    i_req     = 1'b1;
    d_req     = 1'b1;
    i_addr    = 32'h0;
    d_addr    = 32'h0;
    d_wmask   = 4'h0;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;
    ack_force = 1'b1;
    delay     = 0;

    // reset hold
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_mem_req", {31'b0, mem_req}, 0);
      chk("rst_i_rvalid", {31'b0, i_rvalid}, 0);
      chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
    end
    chk("rst_stall", {31'b0, o_stall}, 1);
    chk("rst_mem_addr", mem_addr, 0);
    i_req = 1'b0;
    d_req = 1'b0;
    ack_force = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_mem_req", {31'b0, mem_req}, 0);
    settle();
    chk("idle_stall", {31'b0, o_stall}, 0);

    // single fetch, immediate ack
    i_req = 1'b1;
    i_addr = 32'h0000_0040;
    mem_rdata = 32'h0051_0113;
    settle();
    chk("f_stall_pre", {31'b0, o_stall}, 1);
    tick();
    chk("f_mem_req", {31'b0, mem_req}, 1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_wmask", {28'b0, mem_wmask}, 0);
    chk("f_rvalid_early", {31'b0, i_rvalid}, 0);
    tick();
    chk("f_rvalid", {31'b0, i_rvalid}, 1);
    chk("f_rdata", i_rdata, 32'h0051_0113);
    chk("f_stall_fall", {31'b0, o_stall}, 0);
    chk("f_mem_req_off", {31'b0, mem_req}, 0);
    i_req = 1'b0;
    tick();
    chk("f_rvalid_pulse", {31'b0, i_rvalid}, 0);

    // store with wait states; inputs change after grant
    d_req = 1'b1;
    d_addr = 32'h1000_0004;
    d_wmask = 4'b0011;
    d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    delay = 3;
    tick();
    d_addr = 32'h0BAD_0000;
    d_wmask = 4'b1111;
    d_wdata = 32'h0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      chk("s_mem_req", {31'b0, mem_req}, 1);
      chk("s_mem_addr", mem_addr, 32'h1000_0004);
      chk("s_mem_wmask", {28'b0, mem_wmask}, 4'b0011);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (d_rvalid) pulses++;
      tick();
    end
    chk("s_rvalid", {31'b0, d_rvalid}, 1);
    chk("s_mem_req_off", {31'b0, mem_req}, 0);
    settle();
    chk("s_stall_fall", {31'b0, o_stall}, 0);
    if (d_rvalid) pulses++;
    d_req = 1'b0;
    tick();
    if (d_rvalid) pulses++;
    tick();
    if (d_rvalid) pulses++;
    chk("s_pulses", pulses, 1);

    // conflict: data first, then a held conflict
    delay = 0;
    i_req = 1'b1;
    d_req = 1'b1;
    i_addr = 32'h80;
    d_addr = 32'h200;
    d_wmask = 4'h0;
    mem_rdata = 32'h1111_1111;
    tick();
    chk("c1_addr", mem_addr, 32'h200);
    tick();
    chk("c1_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("c1_i_rvalid", {31'b0, i_rvalid}, 0);
    chk("c1_d_rdata", d_rdata, 32'h1111_1111);
    chk("c1_stall", {31'b0, o_stall}, 1);
    mem_rdata = 32'h2222_2222;
    tick();
    tick();
`ifdef ARB_RR_EN
    exp_addr = 32'h80;
`else
    exp_addr = 32'h200;
`endif
    chk("c2_addr", mem_addr, exp_addr);
    tick();
`ifdef ARB_RR_EN
    chk("c2_i_rvalid", {31'b0, i_rvalid}, 1);
    chk("c2_i_rdata", i_rdata, 32'h2222_2222);
`else
    chk("c2_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("c2_d_rdata", d_rdata, 32'h2222_2222);
`endif
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

`ifndef ARB_RR_EN
    // starvation under fixed priority
    i_req = 1'b1;
    d_req = 1'b1;
    i_addr = 32'h84;
    d_addr = 32'h204;
    mem_rdata = 32'h4444_4444;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("sv_addr", mem_addr, 32'h204);
      chk("sv_i_rv_b", {31'b0, i_rvalid}, 0);
      tick();
      chk("sv_d_rvalid", {31'b0, d_rvalid}, 1);
      chk("sv_i_rv_r", {31'b0, i_rvalid}, 0);
      tick();
      chk("sv_i_rv_i", {31'b0, i_rvalid}, 0);
    end
    d_req = 1'b0;
    mem_rdata = 32'h5555_5555;
    tick();
    chk("sv_f_addr", mem_addr, 32'h84);
    tick();
    chk("sv_f_rvalid", {31'b0, i_rvalid}, 1);
    chk("sv_f_rdata", i_rdata, 32'h5555_5555);
    i_req = 1'b0;
    tick();
`endif

    // reset during BUSY_D
    d_req = 1'b1;
    d_addr = 32'h300;
    delay = 100;
    tick();
    chk("r_mem_req", {31'b0, mem_req}, 1);
    rst = 1'b0;
    tick();
    chk("r_mem_req_off", {31'b0, mem_req}, 0);
    chk("r_d_rvalid", {31'b0, d_rvalid}, 0);
    chk("r_mem_addr", mem_addr, 0);
    rst = 1'b1;
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r_no_rvalid", {31'b0, d_rvalid}, 0);
      chk("r_idle", {31'b0, mem_req}, 0);
    end

    // fresh fetch after reset, one wait state
    i_req = 1'b1;
    i_addr = 32'h44;
    delay = 1;
    mem_rdata = 32'h3333_3333;
    tick();
    chk("rf_addr", mem_addr, 32'h44);
    tick();
    chk("rf_wait", {31'b0, mem_req}, 1);
    chk("rf_rv_wait", {31'b0, i_rvalid}, 0);
    tick();
    chk("rf_rvalid", {31'b0, i_rvalid}, 1);
    chk("rf_rdata", i_rdata, 32'h3333_3333);
    i_req = 1'b0;
    tick();
    chk("rf_done", {31'b0, i_rvalid}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
